fifo_corner_monitor: RTL and testbench

Synthesisable hardware coverage collector for FIFO corner cases. It watches a FIFO's push/pop/flag/count/data signals and detects 12 corner-case bins, including multi-cycle sequences. For each bin it keeps a per-cycle hit pulse, a sticky hit bit and a saturating hit counter. It sits beside any parametrised FIFO in emulation or silicon-debug builds, and its counters are read through a simple select/mux port.

---
 rtl/fifo_corner_monitor_if.sv | 15 +
 rtl/fifo_corner_monitor.sv | 139 +++++++++++++
 tb/tb_fifo_corner_monitor.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_corner_monitor_if.sv
// Observation bundle for the FIFO under monitor: handshake, flags, occupancy and write data.
interface fifo_corner_monitor_if #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32
) ();
  logic                         push;
  logic                         pop;
  logic                         full;
  logic                         empty;
  logic [$clog2(DEPTH+1)-1:0]   count;
  logic [DATA_W-1:0]            wr_data;

  modport master (output push, pop, full, empty, count, wr_data);
  modport slave  (input  push, pop, full, empty, count, wr_data);
endinterface

// File: rtl/fifo_corner_monitor.sv
// FIFO corner-case coverage collector: 12 bins, each with a hit pulse, a sticky bit
// and a saturating counter readable through rd_sel/rd_cnt.
module fifo_corner_monitor #(
  parameter int DEPTH    = 16,
  parameter int DATA_W   = 32,
  parameter int CNT_W    = 16,
  parameter int IDLE_LEN = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  fifo_corner_monitor_if.slave  fif,
  input  logic [3:0]            rd_sel,
  output logic [CNT_W-1:0]      rd_cnt,
  output logic [11:0]           hit_pulse,
  output logic [11:0]           hit_sticky,
  output logic                  all_hit
);
  localparam int NB = 12;
  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(IDLE_LEN+1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_HALF = CW'(DEPTH/2);
  localparam logic [CW-1:0] C_ALM  = CW'(DEPTH-1);
  localparam logic [CW-1:0] RUN_TGT  = CW'(DEPTH);
  localparam logic [IW-1:0] IDLE_TGT = IW'(IDLE_LEN);

  localparam logic [2:0] A0 = 3'd0, A1 = 3'd1, A2 = 3'd2, A3 = 3'd3, A4 = 3'd4;
  localparam logic [0:0] FD_IDLE = 1'b0, FD_DRAIN = 1'b1;

  logic p, q, wp, rp, idl;
  assign p   = fif.push & ~fif.pop;
  assign q   = fif.pop & ~fif.push;
  assign wp  = fif.push & ~fif.full;
  assign rp  = fif.pop & ~fif.empty;
  assign idl = ~fif.push & ~fif.pop;

  logic          h_vld, h_af, h_ae;
  logic [CW-1:0] push_run, pop_run, push_run_nxt, pop_run_nxt;
  logic [IW-1:0] idle_run, idle_run_nxt;
  logic [2:0]    alt_st, alt_nxt;
  logic [0:0]    fd_st, fd_nxt;
  logic          alt_hit, fd_hit, alt_match;
  logic [NB-1:0] det;
  logic [CNT_W-1:0] cnt [NB];

  // Run counters park at their target so a long run reports only once.
  always_comb begin
    push_run_nxt = '0;
    pop_run_nxt  = '0;
    idle_run_nxt = '0;
    if (wp)  push_run_nxt = (push_run == RUN_TGT)  ? push_run : push_run + 1'b1;
    if (rp)  pop_run_nxt  = (pop_run  == RUN_TGT)  ? pop_run  : pop_run  + 1'b1;
    if (idl) idle_run_nxt = (idle_run == IDLE_TGT) ? idle_run : idle_run + 1'b1;
  end

  // Even states expect P, odd states expect Q; a completed pattern's last P seeds the next one.
  always_comb begin
    alt_hit   = 1'b0;
    alt_match = alt_st[0] ? q : p;
    alt_nxt   = p ? A1 : A0;
    if (alt_match) begin
      if (alt_st == A4) begin
        alt_hit = 1'b1;
        alt_nxt = A1;
      end else begin
        alt_nxt = alt_st + 3'd1;
      end
    end
    if (alt_st > A4) alt_nxt = A0;
  end

  always_comb begin
    fd_hit = 1'b0;
    fd_nxt = fd_st;
    if (fd_st == FD_IDLE) begin
      if (fif.full && q) fd_nxt = FD_DRAIN;
    end else if (fif.empty) begin
      fd_hit = 1'b1;
      fd_nxt = FD_IDLE;
    end else if (q) begin
      fd_nxt = FD_DRAIN;
    end else begin
      fd_nxt = (fif.full && q) ? FD_DRAIN : FD_IDLE;
    end
  end

  always_comb begin
    det     = '0;
    det[0]  = (fif.count == C_ONE);
    det[1]  = fif.push & fif.pop & (fif.count == C_HALF);
    det[2]  = h_vld & h_af & fif.full;
    det[3]  = h_vld & h_ae & fif.empty;
    det[4]  = wp  & (push_run == RUN_TGT - 1'b1);
    det[5]  = rp  & (pop_run  == RUN_TGT - 1'b1);
    det[6]  = alt_hit;
    det[7]  = idl & (idle_run == IDLE_TGT - 1'b1);
    det[8]  = fif.push & (fif.wr_data == '0);
    det[9]  = fif.push & (fif.wr_data == '1);
    det[10] = fif.push & (fif.wr_data != '0) &
              ((fif.wr_data & (fif.wr_data - 1'b1)) == '0);
    det[11] = fd_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_vld <= 1'b0; h_af <= 1'b0; h_ae <= 1'b0;
      push_run <= '0; pop_run <= '0; idle_run <= '0;
      alt_st <= A0; fd_st <= FD_IDLE;
      hit_pulse <= '0; hit_sticky <= '0; all_hit <= 1'b0;
      for (int b = 0; b < NB; b++) cnt[b] <= '0;
    end else if (clear) begin
      h_vld <= 1'b0; h_af <= 1'b0; h_ae <= 1'b0;
      push_run <= '0; pop_run <= '0; idle_run <= '0;
      alt_st <= A0; fd_st <= FD_IDLE;
      hit_pulse <= '0; hit_sticky <= '0; all_hit <= 1'b0;
      for (int b = 0; b < NB; b++) cnt[b] <= '0;
    end else begin
      h_vld    <= 1'b1;
      h_af     <= (fif.count == C_ALM) & p & ~fif.full;
      h_ae     <= (fif.count == C_ONE) & q & ~fif.empty;
      push_run <= push_run_nxt;
      pop_run  <= pop_run_nxt;
      idle_run <= idle_run_nxt;
      alt_st   <= alt_nxt;
      fd_st    <= fd_nxt;
      hit_pulse  <= det;
      hit_sticky <= hit_sticky | det;
      all_hit    <= &(hit_sticky | det);
      for (int b = 0; b < NB; b++)
        if (det[b] && cnt[b] != '1) cnt[b] <= cnt[b] + 1'b1;
    end
  end

  always_comb begin
    rd_cnt = '0;
    if (rd_sel < 4'd12) rd_cnt = cnt[rd_sel];
  end
endmodule

// File: tb/tb_fifo_corner_monitor.sv
// Directed bench: a table of single-cycle vectors plus hand sequences for the multi-cycle bins.
module tb_fifo_corner_monitor;
  localparam int DEPTH = 16, DATA_W = 32, CNT_W = 4, IDLE_LEN = 10;
  localparam int CW = $clog2(DEPTH+1);

  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
  logic [3:0]       rd_sel = 4'd0;
  logic [CNT_W-1:0] rd_cnt;
  logic [11:0]      hit_pulse, hit_sticky;
  logic             all_hit;

  fifo_corner_monitor_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) fif ();

  fifo_corner_monitor #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CNT_W(CNT_W), .IDLE_LEN(IDLE_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .fif(fif), .rd_sel(rd_sel),
    .rd_cnt(rd_cnt), .hit_pulse(hit_pulse), .hit_sticky(hit_sticky), .all_hit(all_hit)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        push, pop, full, empty;
    int          cnt;
    logic [31:0] data;
    logic [11:0] exp;
  } vec_t;
  vec_t tbl [10];

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic pu, input logic po, input logic fu, input logic em,
                     input int c, input logic [31:0] d);
    fif.push = pu; fif.pop = po; fif.full = fu; fif.empty = em;
    fif.count = CW'(c); fif.wr_data = d;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic step(input logic pu, input logic po, input logic fu, input logic em,
                      input int c, input logic [31:0] d);
    drv(pu, po, fu, em, c, d);
    tick();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b1, 0, 32'h0);
    clear = 1'b0;
  endtask

  task automatic rdc(input string nm, input int sel, input logic [31:0] exp);
    rd_sel = 4'(sel);
    #1;
    chk(nm, 32'(rd_cnt), exp);
  endtask

  // 16 pushes from empty, then the full cycle after the last one.
  task automatic seq_push();
    for (int k = 0; k < 16; k++) step(1'b1, 1'b0, 1'b0, (k == 0), k, 32'h1234_5678);
    step(1'b0, 1'b0, 1'b1, 1'b0, 16, 32'h0);
  endtask

  task automatic seq_drain();
    step(1'b0, 1'b1, 1'b1, 1'b0, 16, 32'h0);
    for (int c = 15; c >= 1; c--) step(1'b0, 1'b1, 1'b0, 1'b0, c, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 0, 32'h0);
  endtask

  // e: 1=P, 2=Q, 0=idle
  task automatic alt_el(input int e);
    case (e)
      1:       step(1'b1, 1'b0, 1'b0, 1'b0, 4, 32'h5);
      2:       step(1'b0, 1'b1, 1'b0, 1'b0, 5, 32'h5);
      default: step(1'b0, 1'b0, 1'b0, 1'b0, 4, 32'h5);
    endcase
  endtask

  task automatic seq_alt9();
    for (int k = 0; k < 9; k++) alt_el((k % 2 == 0) ? 1 : 2);
  endtask

  task automatic seq_data();
    step(1'b1, 1'b0, 1'b0, 1'b0, 2, 32'h0000_0000);
    step(1'b1, 1'b0, 1'b0, 1'b0, 3, 32'hFFFF_FFFF);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4, 32'h0001_0000);
    step(1'b1, 1'b0, 1'b0, 1'b0, 5, 32'h0000_0003);
  endtask

  initial begin
    int alt2 [10];
    int pulses;
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1,  32'h0,         12'h001};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 8,  32'h5,         12'h002};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 3,  32'h0,         12'h100};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 3,  32'hFFFF_FFFF, 12'h200};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 3,  32'h0001_0000, 12'h400};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 3,  32'h3,         12'h000};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1,  32'h8000_0000, 12'h401};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 8,  32'h0,         12'h000};
    tbl[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 8,  32'h0,         12'h102};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 0,  32'h0,         12'h000};
    alt2 = '{1, 2, 1, 0, 2, 1, 2, 1, 2, 1};

    drv(1'b0, 1'b0, 1'b0, 1'b1, 0, 32'h0);
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_pulse", 32'(hit_pulse), 32'h0);
    chk("rst_sticky", 32'(hit_sticky), 32'h0);
    chk("rst_all_hit", 32'(all_hit), 32'h0);
    rdc("rst_cnt0", 0, 0);
    rdc("rst_cnt11", 11, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      do_clear();
      step(tbl[i].push, tbl[i].pop, tbl[i].full, tbl[i].empty, tbl[i].cnt, tbl[i].data);
      chk($sformatf("vec%0d_pulse", i), 32'(hit_pulse), 32'(tbl[i].exp));
      chk($sformatf("vec%0d_sticky", i), 32'(hit_sticky), 32'(tbl[i].exp));
    end

    do_clear();
    seq_push();
    chk("push_almost_full_pulse", 32'(hit_pulse[2]), 32'h1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 16, 32'h0);
    rdc("consec_push_cnt", 4, 1);
    rdc("almost_full_cnt", 2, 1);
    chk("consec_push_sticky", 32'(hit_sticky[4]), 32'h1);

    do_clear();
    seq_drain();
    chk("drain_pulse", 32'(hit_pulse[11]), 32'h1);
    chk("almost_empty_pulse", 32'(hit_pulse[3]), 32'h1);
    rdc("full_drain_cnt", 11, 1);
    rdc("almost_empty_cnt", 3, 1);
    rdc("consec_pop_cnt", 5, 1);

    do_clear();
    step(1'b0, 1'b1, 1'b1, 1'b0, 16, 32'h0);
    for (int c = 15; c >= 9; c--) step(1'b0, 1'b1, 1'b0, 1'b0, c, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8, 32'h0);
    for (int c = 9; c >= 1; c--) step(1'b0, 1'b1, 1'b0, 1'b0, c, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 0, 32'h0);
    rdc("drain_broken_cnt", 11, 0);

    do_clear();
    seq_alt9();
    rdc("alt9_cnt", 6, 2);
    do_clear();
    for (int k = 0; k < 10; k++) alt_el(alt2[k]);
    rdc("alt_gap_cnt", 6, 1);

    do_clear();
    seq_data();
    rdc("data_zero_cnt", 8, 1);
    rdc("data_ones_cnt", 9, 1);
    rdc("data_onehot_cnt", 10, 1);
    rdc("data_one_entry_cnt", 0, 0);

    do_clear();
    seq_push();
    seq_drain();
    seq_alt9();
    seq_data();
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 1'b0, 1'b1, 0, 32'h0);
    chk("accum_sticky", 32'(hit_sticky), 32'hFFD);
    chk("accum_all_hit_lo", 32'(all_hit), 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8, 32'h5);
    chk("accum_sticky_full", 32'(hit_sticky), 32'hFFF);
    chk("accum_all_hit", 32'(all_hit), 32'h1);

    for (int k = 0; k < 20; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 1, 32'h0);
    chk("sat_pulse", 32'(hit_pulse[0]), 32'h1);
    rdc("sat_cnt0", 0, 15);
    chk("sat_all_hit", 32'(all_hit), 32'h1);
    do_clear();
    chk("clr_sticky", 32'(hit_sticky), 32'h0);
    chk("clr_all_hit", 32'(all_hit), 32'h0);
    chk("clr_pulse", 32'(hit_pulse), 32'h0);
    rdc("clr_cnt0", 0, 0);
    rdc("clr_cnt4", 4, 0);
    rdc("clr_cnt11", 11, 0);
    rdc("sel_oob", 13, 0);

    do_clear();
    for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 1'b0, 1'b1, 0, 32'h0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 0, 32'h0);
      chk($sformatf("idle_rst_c%0d", k), 32'(hit_pulse[7]), (k == 10) ? 32'h1 : 32'h0);
      pulses += int'(hit_pulse[7]);
    end
    chk("idle_rst_pulses", 32'(pulses), 32'h1);
    rdc("idle_rst_cnt", 7, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
